// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request/response port between NUM_REQ requesters.
// Round-robin by default; define MEM_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins priority.
module mem_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MASK_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 4,
   localparam int IDX_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int OUT_ID_WIDTH = ID_WIDTH + IDX_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   // requester side, request path
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_read_enable,
   input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_write_enable,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   input  logic [NUM_REQ*ID_WIDTH-1:0]      req_id,
   // memory side, request path
   output logic                             mem_req_valid,
   input  logic                             mem_req_ready,
   output logic                             mem_req_read_enable,
   output logic [MASK_WIDTH-1:0]            mem_req_write_enable,
   output logic [ADDR_WIDTH-1:0]            mem_req_addr,
   output logic [DATA_WIDTH-1:0]            mem_req_data,
   output logic [OUT_ID_WIDTH-1:0]          mem_req_id,
   // memory side, response path
   input  logic                             mem_resp_valid,
   output logic                             mem_resp_ready,
   input  logic [DATA_WIDTH-1:0]            mem_resp_data,
   input  logic [OUT_ID_WIDTH-1:0]          mem_resp_id,
   // requester side, response path
   output logic [NUM_REQ-1:0]               resp_valid,
   input  logic [NUM_REQ-1:0]               resp_ready,
   output logic [DATA_WIDTH-1:0]            resp_data,
   output logic [ID_WIDTH-1:0]              resp_id
);

   logic [IDX_WIDTH-1:0] ptr;
   logic [IDX_WIDTH-1:0] winner;
   logic [IDX_WIDTH-1:0] hi_idx;
   logic [IDX_WIDTH-1:0] lo_idx;
   logic                 has_hi;
   logic                 found;
   logic                 slot_free;
   logic                 accept;
   logic [IDX_WIDTH-1:0] resp_idx;

   assign slot_free = !mem_req_valid || mem_req_ready;

   // ---------------------------------------------------------------------
   // Search start pointer
   // ---------------------------------------------------------------------
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
   assign ptr = '0;
`else
   // NOTE: sequential state is always updated with non-blocking assignments.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (winner == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : winner + IDX_WIDTH'(1);
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Arbitration: lowest valid index at or above ptr, else lowest valid overall
   // (equivalent to an ascending search from ptr that wraps modulo NUM_REQ).
   // ---------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      hi_idx = '0;
      lo_idx = '0;
      has_hi = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_idx = IDX_WIDTH'(i);
            if (IDX_WIDTH'(i) >= ptr) begin
               hi_idx = IDX_WIDTH'(i);
               has_hi = 1'b1;
            end
         end
      end
   end

   assign winner = has_hi ? hi_idx : lo_idx;
   assign found  = |req_valid;
   assign accept = found && slot_free && rst;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = accept && (winner == IDX_WIDTH'(i));
      end
   end

   // ---------------------------------------------------------------------
   // One-entry output slot
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req_valid        <= 1'b0;
         mem_req_read_enable  <= 1'b0;
         mem_req_write_enable <= '0;
         mem_req_addr         <= '0;
         mem_req_data         <= '0;
         mem_req_id           <= '0;
      end else if (accept) begin
         mem_req_valid        <= 1'b1;
         mem_req_read_enable  <= req_read_enable[winner];
         mem_req_write_enable <= req_write_enable[winner*MASK_WIDTH +: MASK_WIDTH];
         mem_req_addr         <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
         mem_req_data         <= req_data[winner*DATA_WIDTH +: DATA_WIDTH];
         mem_req_id           <= {winner, req_id[winner*ID_WIDTH +: ID_WIDTH]};
      end else if (slot_free) begin
         // payload is left as-is; only the valid flag matters once drained
         mem_req_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Response demux, keyed on the index field of the returned ID
   // ---------------------------------------------------------------------
   assign resp_idx  = mem_resp_id[OUT_ID_WIDTH-1:ID_WIDTH];
   assign resp_data = mem_resp_data;
   assign resp_id   = mem_resp_id[ID_WIDTH-1:0];

   // an index with no matching requester keeps ready high so the response drains
   always_comb begin
      resp_valid     = '0;
      mem_resp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (resp_idx == IDX_WIDTH'(i)) begin
            resp_valid[i]  = mem_resp_valid;
            mem_resp_ready = resp_ready[i];
         end
      end
   end

`ifndef SYNTHESIS
   a_single_grant: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));

   a_stall_hold: assert property (@(posedge clk) disable iff (!rst)
      (mem_req_valid && !mem_req_ready) |=>
         (mem_req_valid && $stable(mem_req_addr) && $stable(mem_req_id) && $stable(mem_req_data)));

   a_no_grant_in_stall: assert property (@(posedge clk) disable iff (!rst)
      (mem_req_valid && !mem_req_ready) |-> (req_ready == '0));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized scoreboard bench for mem_arbiter (NUM_REQ=3).
// Reference model follows the arbitration/routing rules directly; a monitor pops expectations.
module tb_mem_arbiter;
   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int IW = 4;
   localparam int XW = 2;
   localparam int OW = IW + XW;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_read_enable;
   logic [N*MW-1:0] req_write_enable;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N*IW-1:0] req_id;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_read_enable;
   logic [MW-1:0]   mem_req_write_enable;
   logic [AW-1:0]   mem_req_addr;
   logic [DW-1:0]   mem_req_data;
   logic [OW-1:0]   mem_req_id;
   logic            mem_resp_valid;
   logic            mem_resp_ready;
   logic [DW-1:0]   mem_resp_data;
   logic [OW-1:0]   mem_resp_id;
   logic [N-1:0]    resp_valid;
   logic [N-1:0]    resp_ready;
   logic [DW-1:0]   resp_data;
   logic [IW-1:0]   resp_id;

   mem_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ID_WIDTH(IW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_read_enable(req_read_enable),
      .req_write_enable(req_write_enable), .req_addr(req_addr), .req_data(req_data),
      .req_id(req_id),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_read_enable(mem_req_read_enable), .mem_req_write_enable(mem_req_write_enable),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_id(mem_req_id),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_data(mem_resp_data), .mem_resp_id(mem_resp_id),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_id(resp_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          re;
      logic [MW-1:0] we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [OW-1:0] id;
   } req_t;

   typedef struct {
      logic [N-1:0]  valid;
      logic          ready;
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } resp_t;

   req_t  exp_q[$];
   resp_t resp_q[$];
   req_t  mon_req;
   resp_t mon_resp;

   int passed = 0;
   int total  = 0;

   // reference model state: where the next search starts, and whether the slot holds a request
   int rr_start  = 0;
   bit slot_full = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic int model_winner(input logic [N-1:0] v);
      int s;
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
      s = 0;
`else
      s = rr_start;
`endif
      for (int k = 0; k < N; k++) begin
         if (v[(s + k) % N]) return (s + k) % N;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [IW-1:0] id, input logic [MW-1:0] we, input logic re);
      req_addr[i*AW +: AW]         = a;
      req_data[i*DW +: DW]         = d;
      req_id[i*IW +: IW]           = id;
      req_write_enable[i*MW +: MW] = we;
      req_read_enable[i]           = re;
   endtask

   // One clock: check combinational outputs mid-cycle, queue expectations, advance the model.
   task automatic step();
      int           w;
      int           ix;
      bit           free;
      bit           acc;
      logic [N-1:0] exp_ready;
      req_t         t;
      resp_t        r;
      @(negedge clk);
      free = !slot_full || mem_req_ready;
      w    = model_winner(req_valid);
      acc  = free && (w >= 0);
      exp_ready = '0;
      if (acc) exp_ready[w] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("mem_req_valid", mem_req_valid, slot_full);
      if (acc) begin
         t.re   = req_read_enable[w];
         t.we   = req_write_enable[w*MW +: MW];
         t.addr = req_addr[w*AW +: AW];
         t.data = req_data[w*DW +: DW];
         t.id   = {XW'(w), req_id[w*IW +: IW]};
         exp_q.push_back(t);
      end
      if (mem_resp_valid) begin
         ix      = int'(mem_resp_id[OW-1:IW]);
         r.valid = '0;
         r.ready = 1'b1;
         if (ix < N) begin
            r.valid[ix] = 1'b1;
            r.ready     = resp_ready[ix];
         end
         r.id   = mem_resp_id[IW-1:0];
         r.data = mem_resp_data;
         resp_q.push_back(r);
      end else begin
         check("resp_valid_idle", resp_valid, '0);
      end
      @(posedge clk);
      if (acc) begin
         slot_full = 1'b1;
         rr_start  = (w + 1) % N;
      end else if (free) begin
         slot_full = 1'b0;
      end
      #1;
   endtask

   // Monitor: compares whatever the DUT hands over against the queued expectations.
   always begin
      @(negedge clk);
      #1;
      if (rst && mem_req_valid && mem_req_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL mem_req_unexpected: transfer id %0h addr %0h with no expected entry",
                     mem_req_id, mem_req_addr);
         end else begin
            mon_req = exp_q.pop_front();
            check("mem_req_id", mem_req_id, mon_req.id);
            check("mem_req_addr", mem_req_addr, mon_req.addr);
            check("mem_req_data", mem_req_data, mon_req.data);
            check("mem_req_we", mem_req_write_enable, mon_req.we);
            check("mem_req_re", mem_req_read_enable, mon_req.re);
         end
      end
      if (rst && mem_resp_valid) begin
         if (resp_q.size() == 0) begin
            total++;
            $display("FAIL resp_unexpected: response id %0h with no expected entry", mem_resp_id);
         end else begin
            mon_resp = resp_q.pop_front();
            check("resp_valid", resp_valid, mon_resp.valid);
            check("mem_resp_ready", mem_resp_ready, mon_resp.ready);
            check("resp_id", resp_id, mon_resp.id);
            check("resp_data", resp_data, mon_resp.data);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int seq[4];
   int second_after_reset;

   initial begin
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
      seq = '{0, 0, 0, 0};
      second_after_reset = 0;
`else
      seq = '{0, 1, 0, 1};
      second_after_reset = 1;
`endif
      rst              = 1'b0;
      req_valid        = '1;
      req_read_enable  = '0;
      req_write_enable = '0;
      req_addr         = '0;
      req_data         = '0;
      req_id           = '0;
      mem_req_ready    = 1'b1;
      mem_resp_valid   = 1'b0;
      mem_resp_data    = '0;
      mem_resp_id      = '0;
      resp_ready       = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_mem_req_valid", mem_req_valid, 1'b0);
      check("reset_req_ready", req_ready, '0);
      check("reset_mem_req_id", mem_req_id, '0);
      check("reset_mem_req_addr", mem_req_addr, '0);

      // two requesters continuously valid: index field alternates
      set_req(0, 32'h0000_0010, 32'h1111_0000, 4'h1, 4'hF, 1'b0);
      set_req(1, 32'h0000_0020, 32'h2222_0000, 4'h2, 4'h3, 1'b1);
      set_req(2, 32'h0000_0030, 32'h3333_0000, 4'h3, 4'h0, 1'b1);
      req_valid = 3'b011;
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rr_alternate_idx", mem_req_id[OW-1:IW], XW'(seq[i]));
      end

      // stall holds the slot for three cycles
      req_valid = 3'b001;
      set_req(0, 32'h0000_0100, 32'hCAFE_0100, 4'h6, 4'h1, 1'b0);
      step();
      mem_req_ready = 1'b0;
      req_valid     = 3'b011;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_addr", mem_req_addr, 32'h0000_0100);
         check("stall_valid", mem_req_valid, 1'b1);
      end
      mem_req_ready = 1'b1;
      step();

      // lone request from the top index, then wrap back to req0
      req_valid = 3'b100;
      set_req(2, 32'h0000_0300, 32'h0BAD_0300, 4'h5, 4'h2, 1'b1);
      step();
      check("wrap_id", mem_req_id, 6'h25);
      req_valid = 3'b011;
      step();
      check("wrap_then_req0", mem_req_id[OW-1:IW], 2'd0);

      // response routed to requester 1, held until it is ready
      req_valid      = '0;
      mem_resp_valid = 1'b1;
      mem_resp_id    = {2'd1, 4'hA};
      mem_resp_data  = 32'hDEAD_BEEF;
      resp_ready     = 3'b101;
      for (int i = 0; i < 2; i++) begin
         step();
         check("resp_route_valid", resp_valid, 3'b010);
         check("resp_route_id", resp_id, 4'hA);
         check("resp_route_data", resp_data, 32'hDEAD_BEEF);
         check("resp_route_ready_low", mem_resp_ready, 1'b0);
      end
      resp_ready = 3'b111;
      #1 check("resp_route_ready_high", mem_resp_ready, 1'b1);
      step();

      // out-of-range index is dropped
      mem_resp_id = {2'd3, 4'h7};
      resp_ready  = 3'b000;
      #1;
      check("resp_oob_ready", mem_resp_ready, 1'b1);
      check("resp_oob_valid", resp_valid, 3'b000);
      step();
      mem_resp_valid = 1'b0;

      // asynchronous reset in the middle of a stall
      req_valid     = 3'b001;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      step();
      #2 rst = 1'b0;
      #1;
      check("async_reset_valid", mem_req_valid, 1'b0);
      check("async_reset_ready", req_ready, '0);
      slot_full = 1'b0;
      rr_start  = 0;
      exp_q.delete();
      @(posedge clk);
      #3 rst = 1'b1;
      req_valid     = 3'b011;
      mem_req_ready = 1'b1;
      step();
      check("post_reset_first", mem_req_id[OW-1:IW], 2'd0);
      step();
      check("post_reset_second", mem_req_id[OW-1:IW], XW'(second_after_reset));

      // randomized traffic on both paths
      for (int n = 0; n < 1500; n++) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            set_req(i, $urandom, $urandom, IW'($urandom), MW'($urandom), 1'($urandom));
         end
         mem_req_ready  = ($urandom_range(3) != 0);
         mem_resp_valid = 1'($urandom_range(1));
         mem_resp_id    = OW'($urandom);
         mem_resp_data  = $urandom;
         resp_ready     = N'($urandom);
         step();
      end

      // drain
      req_valid      = '0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      repeat (3) step();
      check("scoreboard_empty", exp_q.size(), 0);
      check("resp_queue_empty", resp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory request/response port between NUM_REQ requesters.
- Request path: round-robin arbitration into a one-entry registered output slot. The winner's index is prepended to the request ID.
- Response path: combinational demux back to the owning requester, keyed on that index field.
- Sits between several pipeline clients (fetch, load/store, DMA) and a single mem_stage/memory port.

Parameters:
- NUM_REQ, 2, number of requesters (>=1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MASK_WIDTH, DATA_WIDTH/8, write byte-enable width
- ID_WIDTH, 4, requester-side ID width
- IDX_WIDTH (local), NUM_REQ>1 ? $clog2(NUM_REQ) : 1, requester index width
- OUT_ID_WIDTH (local), ID_WIDTH+IDX_WIDTH, memory-side ID width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request ready
- req_read_enable  in  NUM_REQ  read strobe per requester
- req_write_enable  in  NUM_REQ*MASK_WIDTH  byte write enables, requester i at slice i
- req_addr  in  NUM_REQ*ADDR_WIDTH  address per requester
- req_data  in  NUM_REQ*DATA_WIDTH  write data per requester
- req_id  in  NUM_REQ*ID_WIDTH  request ID per requester
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory request ready
- mem_req_read_enable  out  1  read strobe
- mem_req_write_enable  out  MASK_WIDTH  byte enables
- mem_req_addr  out  ADDR_WIDTH  address
- mem_req_data  out  DATA_WIDTH  write data
- mem_req_id  out  OUT_ID_WIDTH  {winner index, requester ID}
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  response ready
- mem_resp_data  in  DATA_WIDTH  response data
- mem_resp_id  in  OUT_ID_WIDTH  response ID ({index, ID})
- resp_valid  out  NUM_REQ  per-requester response valid
- resp_ready  in  NUM_REQ  per-requester response ready
- resp_data  out  DATA_WIDTH  response data, broadcast to all requesters
- resp_id  out  ID_WIDTH  mem_resp_id[ID_WIDTH-1:0], broadcast to all requesters

Behaviour:
- Reset (rst=0, async):
  - mem_req_valid=0; all mem_req_* payload registers=0.
  - Round-robin pointer=0.
  - req_ready=0 while in reset.
- Slot free condition: slot_free = !mem_req_valid || mem_req_ready.
- Arbitration (combinational):
  - Search req_valid starting at the pointer, ascending index, wrapping modulo NUM_REQ.
  - The first set bit is the winner.
  - req_ready[i] = (i==winner) && req_valid[i] && slot_free.
  - At most one req_ready bit is high in any cycle.
- Request transfer:
  - On req_valid[w] && req_ready[w] at edge t, the slot loads the payload and id={w, req_id[w]}, with mem_req_valid=1 from t+1.
  - Latency is one cycle. Full throughput: back-to-back accepts are allowed while mem_req_ready=1.
- Slot draining: if slot_free but no requester is valid, the slot clears (mem_req_valid=0) on the edge where mem_req_ready=1.
- Stall: while mem_req_valid=1 and mem_req_ready=0, the slot holds stable and no requester is granted.
- Pointer update:
  - Updates only on an accepted grant: pointer <= (w==NUM_REQ-1) ? 0 : w+1.
  - It is otherwise unchanged, including during stalls.
- Fairness: any continuously valid requester is granted within NUM_REQ accepted transfers.
- NUM_REQ=1: pointer and index field are constant 0; mem_req_id top bit is 0.
- Response routing (pure combinational, zero latency):
  - idx = mem_resp_id[OUT_ID_WIDTH-1:ID_WIDTH].
  - resp_valid[i] = mem_resp_valid && idx==i.
  - mem_resp_ready = resp_ready[idx].
- Out-of-range response index (idx>=NUM_REQ, non-power-of-2 NUM_REQ): mem_resp_ready=1, all resp_valid=0, so the response is dropped.
- Independence: request and response paths operate concurrently. Response traffic never stalls the request path.
- Reset mid-transfer: a pending slot is discarded and the pointer returns to 0.

Optional Feature:
- Macro: MEM_ARBITER_FIXED_PRIORITY_EN.
- Defined:
  - Winner is the lowest-indexed valid requester.
  - Pointer logic is removed.
  - Starvation is permitted.
- Undefined: round-robin as specified above.
- Response routing is identical in both builds.

Test Plan:
1. NUM_REQ=2, reset, both req_valid=1 continuously, mem_req_ready=1 -> mem_req_id index field alternates 0,1,0,1 starting the cycle after reset release; one transfer per cycle.
2. Req0 addr=0x100, mem_req_ready=0 for 3 cycles -> mem_req_valid=1 with addr=0x100 held stable for 3 cycles; req_ready=0 for all requesters; transfer completes on the 4th cycle.
3. NUM_REQ=3, only req2 valid, id=0x5 -> mem_req_id={2'd2,4'h5}; pointer wraps to 0; next simultaneous req0/req1 grants req0 first.
4. mem_resp_id={1'b1,4'hA}, data=0xDEADBEEF, resp_ready[1]=0 for 2 cycles -> resp_valid=2'b10, resp_id=0xA, mem_resp_ready=0 until resp_ready[1]=1.
5. NUM_REQ=3, mem_resp_id index=3, mem_resp_valid=1 -> mem_resp_ready=1, resp_valid=3'b000.
6. Assert rst=0 mid-stall with mem_req_valid=1 -> mem_req_valid=0 immediately (async); after release, req1 and req0 valid -> req0 granted first; with MEM_ARBITER_FIXED_PRIORITY_EN and both valid, req0 is granted every cycle.
